// File: rtl/leds_padrao.sv
// LED pattern generator for end-of-round feedback.
// A victory latches a persistent pattern (blink-all or chase). An error plays a
// bounded alternating-blink burst and then returns to dark.
module leds_padrao #(
  parameter int unsigned N_LEDS        = 18,
  parameter int unsigned MEIO_PERIODO  = 12_500_000,
  parameter int unsigned MODO_VITORIA  = 0,
  parameter int unsigned N_PISCAS_ERRO = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evento_vitoria,
  input  logic              evento_erro,
  input  logic              limpar,
  output logic [N_LEDS-1:0] LEDR,
  output logic              ativo,
  output logic              vitoria_travada
);

  localparam int unsigned CNT_W = $clog2(MEIO_PERIODO);
  localparam int unsigned POS_W = $clog2(N_LEDS);
  localparam int unsigned NM_W  = $clog2(2 * N_PISCAS_ERRO + 1);

  // Alternating pattern with bit 0 lit (...0101).
  function automatic logic [N_LEDS-1:0] padrao_alt();
    logic [N_LEDS-1:0] p;
    for (int i = 0; i < int'(N_LEDS); i++) begin
      p[i] = ~i[0];
    end
    return p;
  endfunction

  localparam logic [N_LEDS-1:0] PADRAO_ALT = padrao_alt();
  localparam logic [N_LEDS-1:0] FASE0_VIT  = (MODO_VITORIA == 0) ?
                                             {N_LEDS{1'b1}} :
                                             {{(N_LEDS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    VITORIA = 2'd1,
    ERRO    = 2'd2
  } estado_t;

  estado_t           estado;
  logic [CNT_W-1:0]  cnt;
  logic [POS_W-1:0]  pos;
  logic [NM_W-1:0]   nmeio;
  logic [POS_W-1:0]  pos_prox;
  logic [NM_W-1:0]   nmeio_prox;
  logic              fim_meio;

  // Next chase index, next half-period count and half-period boundary flag.
  assign pos_prox   = (pos == POS_W'(N_LEDS - 1)) ? '0 : pos + POS_W'(1);
  assign nmeio_prox = nmeio + NM_W'(1);
  assign fim_meio   = (cnt == CNT_W'(MEIO_PERIODO - 1));

  // State, counters and LED register; priority rst > limpar > vitoria > erro > timing.
  always_ff @(posedge clk) begin
    if (rst || limpar) begin
      estado <= IDLE;
      LEDR   <= '0;
      cnt    <= '0;
      pos    <= '0;
      nmeio  <= '0;
    end else if (evento_vitoria && (estado != VITORIA)) begin
      estado <= VITORIA;
      LEDR   <= FASE0_VIT;
      cnt    <= '0;
      pos    <= '0;
      nmeio  <= '0;
    end else begin
      case (estado)
        VITORIA: begin
          if (fim_meio) begin
            cnt <= '0;
            if (MODO_VITORIA == 0) begin
              LEDR <= ~LEDR;
            end else begin
              pos  <= pos_prox;
              LEDR <= N_LEDS'(1) << pos_prox;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ERRO: begin
          if (evento_erro) begin
            LEDR  <= PADRAO_ALT;
            cnt   <= '0;
            nmeio <= '0;
          end else if (fim_meio) begin
            cnt <= '0;
            if (nmeio_prox == NM_W'(2 * N_PISCAS_ERRO)) begin
              estado <= IDLE;
              LEDR   <= '0;
              nmeio  <= '0;
            end else begin
              nmeio <= nmeio_prox;
              LEDR  <= ~LEDR;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          pos   <= '0;
          nmeio <= '0;
          if (evento_erro) begin
            estado <= ERRO;
            LEDR   <= PADRAO_ALT;
          end else begin
            estado <= IDLE;
            LEDR   <= '0;
          end
        end
      endcase
    end
  end

  // Status flags decoded directly from the state register.
  assign ativo           = (estado != IDLE);
  assign vitoria_travada = (estado == VITORIA);

endmodule

// File: tb/tb_leds_padrao.sv
// Bench for leds_padrao: blink-mode and chase-mode instances share stimulus and
// are compared against a time-since-event reference model.
module tb_leds_padrao;

  localparam int unsigned NL = 8;
  localparam int unsigned MP = 4;
  localparam int unsigned NP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ev  = 1'b0;
  logic       ee  = 1'b0;
  logic       lim = 1'b0;
  logic [7:0] led0, led1;
  logic       at0, at1, vt0, vt1;

  int checks = 0;
  int errors = 0;
  int t      = 0;
  int mst    = 0;   // 0 idle, 1 victory, 2 error
  int t0     = 0;   // edge at which the current pattern started

  always #5 clk = ~clk;

  leds_padrao #(.N_LEDS(NL), .MEIO_PERIODO(MP), .MODO_VITORIA(0), .N_PISCAS_ERRO(NP)) dut0 (
    .clk(clk), .rst(rst), .evento_vitoria(ev), .evento_erro(ee), .limpar(lim),
    .LEDR(led0), .ativo(at0), .vitoria_travada(vt0)
  );

  leds_padrao #(.N_LEDS(NL), .MEIO_PERIODO(MP), .MODO_VITORIA(1), .N_PISCAS_ERRO(NP)) dut1 (
    .clk(clk), .rst(rst), .evento_vitoria(ev), .evento_erro(ee), .limpar(lim),
    .LEDR(led1), .ativo(at1), .vitoria_travada(vt1)
  );

  // Expected LEDs from the number of edges elapsed since the pattern started.
  function automatic logic [7:0] esperado(int modo);
    int k;
    k = (t - t0) / int'(MP);
    case (mst)
      1: begin
        if (modo == 0) return (k % 2 == 0) ? 8'hFF : 8'h00;
        else           return 8'(1 << (k % int'(NL)));
      end
      2:       return (k % 2 == 0) ? 8'h55 : 8'hAA;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  // One clock edge: apply inputs, advance the model, check both instances.
  task automatic step(input logic v, input logic e, input logic l, input logic r);
    ev = v; ee = e; lim = l; rst = r;
    @(posedge clk);
    t++;
    if (r || l) begin
      mst = 0;
    end else if (v && mst != 1) begin
      mst = 1; t0 = t;
    end else if (e && mst != 1) begin
      mst = 2; t0 = t;
    end else if (mst == 2 && (t - t0) >= int'(2 * NP * MP)) begin
      mst = 0;
    end
    @(negedge clk);
    ev = 1'b0; ee = 1'b0; lim = 1'b0; rst = 1'b0;
    chk("led_piscar",  led0, esperado(0));
    chk("led_corrida", led1, esperado(1));
    chk("ativo0",   {7'd0, at0}, {7'd0, 1'(mst != 0)});
    chk("ativo1",   {7'd0, at1}, {7'd0, 1'(mst != 0)});
    chk("travada0", {7'd0, vt0}, {7'd0, 1'(mst == 1)});
    chk("travada1", {7'd0, vt1}, {7'd0, 1'(mst == 1)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset for two edges, then quiet idle
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);

    // Victory: blink / chase over a full chase revolution, late erro ignored
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(10);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(26);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Error burst runs to completion
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(19);

    // Error burst restarted six edges in
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(19);

    // Victory and error together: victory wins
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(6);
    // limpar and victory together: idle
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    // Reset in the middle of victory
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // Victory out of an error burst
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized event traffic
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 99) < 3),
           1'($urandom_range(0, 99) < 5),
           1'($urandom_range(0, 99) < 2),
           1'($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
